fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch controller that owns the `pc` input of the `insmem` instruction memory. It sequences word-indexed fetches, detects a HALT opcode and handles branch/jump redirects. It also buffers fetched instructions in a 2-entry queue with a valid/ready handshake toward decode, so decode stalls never drop or duplicate an instruction.

## Interface
- `PC_WIDTH`, 32, width of `pc` / word address.
- `INS_WIDTH`, 32, instruction width (matches `inscode`).
- `RESET_PC`, 0, first word address fetched after start.
- `HALT_OPCODE`, 6'h3F, value of `inscode[31:26]` that stops fetching.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `start`  in  1  leave IDLE and begin fetching at `RESET_PC`.
- `pc`  out  PC_WIDTH  word address driven to `insmem.pc`.
- `inscode`  in  INS_WIDTH  `insmem` read data; combinational from `pc`, same cycle.
- `redirect`  in  1  branch/jump taken; one-cycle pulse.
- `redirect_pc`  in  PC_WIDTH  target word address, valid with `redirect`.
- `ins_valid`  out  1  queue head valid.
- `ins_ready`  in  1  decode accepts head this cycle.
- `ins_out`  out  INS_WIDTH  queue head instruction.
- `ins_pc`  out  PC_WIDTH  address of `ins_out`.
- `halted`  out  1  high in HALT state.
- `fetch_count`  out  32  instructions enqueued since reset, wraps mod 2^32.

## Operation
- States: IDLE, FETCH, HALT.
- Reset (async, `reset`=0) values: state IDLE, `pc`=RESET_PC, queue empty, `ins_valid`=0, `ins_out`=0, `ins_pc`=0, `halted`=0, `fetch_count`=0.
- IDLE: no enqueue; `start`=1 → FETCH. `redirect` ignored.
- FETCH, per cycle, priority order:
  - `redirect`=1: flush queue (count→0), `pc`←`redirect_pc`, no enqueue this cycle. A handshake in this cycle is still accepted by decode; the flush discards all remaining entries.
  - Else if `inscode[31:26]`==HALT_OPCODE: no enqueue, `pc` holds, → HALT.
  - Else if enqueue allowed (count<2, or count==2 with dequeue this cycle): push {`pc`,`inscode`}, `pc`←`pc`+1 mod 2^PC_WIDTH, `fetch_count`+1.
  - Else: `pc` holds (stall).
- HALT: `halted`=1, `pc` holds at HALT address, `redirect` and `start` ignored. Queue keeps draining. Exit only via reset.
- Dequeue when `ins_valid`&&`ins_ready`; empty queue ignores `ins_ready`.
- Simultaneous enqueue and dequeue with count==1 or 2: count unchanged, order preserved.

## Timing
- `pc` and `inscode` are related combinationally. An instruction is captured at the edge ending the cycle it was presented.
- Fetch-to-`ins_valid` latency: 1 cycle into an empty queue.
- Throughput: 1 instruction/cycle with `ins_ready` held high.
- `start` sampled at edge in IDLE; first enqueue occurs in the cycle after the transition (`pc`=RESET_PC).
- Redirect: `ins_valid`=0 the cycle after `redirect`. The target instruction is enqueued that same cycle and is visible one cycle later (2 edges after the redirect edge).
- The enqueue-allowed term depends combinationally on `ins_ready`. This is the only input-to-internal combinational path besides `inscode`.
- Reset mid-operation: immediate return to reset values; the queued instructions are lost.

## Structure
- Package `fetch_pkg`: state enum (IDLE, FETCH, HALT), `HALT_OPCODE` default, queue depth constant 2.
- Sub-module `fetch_fifo`: 2-entry FIFO of {pc, instruction} with push, pop, flush, count, head outputs, async active-low reset.
- Top: FSM, `pc` register, `fetch_count`, opcode compare.

## Test plan
- Reset, `start` pulse, `insmem` words 0..3 non-HALT, `ins_ready`=1 → `ins_pc` 0,1,2,3 on consecutive cycles; `fetch_count`=4 after 4 enqueues.
- `ins_ready`=0 for 5 cycles after start → queue holds `ins_pc` 0 and 1, `pc` stalls at 2, `fetch_count`=2. Release `ins_ready` → 0,1,2 in order, no duplicates.
- Redirect to 0x40 with 2 entries queued → next cycle `ins_valid`=0. The cycle after, `ins_valid`=1 with `ins_pc`=0x40.
- Word 2 = 0xFC000000 (HALT) → `ins_pc` 0,1 delivered, `halted`=1, `pc` stays 2, `fetch_count`=2. A later `redirect` leaves `pc` at 2.
- `pc` at 2^PC_WIDTH-1 in FETCH → next `pc`=0, no stall.
- Assert `reset`=0 mid-burst between edges → outputs go to reset values immediately. After release, state IDLE until `start`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its
// decode-side queue.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'h3F;
  localparam int         QUEUE_DEPTH         = 2;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instruction} queue. Slot 0 is always the head, so a pop
// shifts slot 1 down and the head outputs come straight from registers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int INS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [PC_WIDTH-1:0]  push_pc_i,
  input  logic [INS_WIDTH-1:0] push_ins_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [1:0]           count_o,
  output logic                 head_valid_o,
  output logic [PC_WIDTH-1:0]  head_pc_o,
  output logic [INS_WIDTH-1:0] head_ins_o
);

  logic [PC_WIDTH-1:0]  pc_q  [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0]  pc_d  [QUEUE_DEPTH];
  logic [INS_WIDTH-1:0] ins_q [QUEUE_DEPTH];
  logic [INS_WIDTH-1:0] ins_d [QUEUE_DEPTH];
  logic [1:0]           count_q;
  logic [1:0]           count_d;

  logic pop_ok;
  logic push_ok;
  logic wr_slot;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q < 2'(QUEUE_DEPTH)) || pop_ok);
  // Slot the new entry lands in after any same-cycle pop has shifted the head.
  assign wr_slot = (count_q == 2'd2) || ((count_q == 2'd1) && !pop_ok);

  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_ok) begin
        pc_d[0]  = pc_q[1];
        ins_d[0] = ins_q[1];
      end
      if (push_ok) begin
        pc_d[wr_slot]  = push_pc_i;
        ins_d[wr_slot] = push_ins_i;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != 2'd0);
  assign head_pc_o    = pc_q[0];
  assign head_ins_o   = ins_q[0];

endmodule : fetch_fifo

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives insmem pc, captures the returned word
// into a 2-entry queue toward decode, and handles HALT and redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INS_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [5:0]          HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [PC_WIDTH-1:0]  pc,
  input  logic [INS_WIDTH-1:0] inscode,
  input  logic                 redirect,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [INS_WIDTH-1:0] ins_out,
  output logic [PC_WIDTH-1:0]  ins_pc,
  output logic                 halted,
  output logic [31:0]          fetch_count
);

  fetch_state_e        state_q;
  fetch_state_e        state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [31:0]         fetch_count_q;
  logic [31:0]         fetch_count_d;

  logic       push;
  logic       flush;
  logic       deq;
  logic       enq_ok;
  logic       is_halt;
  logic [1:0] q_count;

  assign is_halt = (inscode[INS_WIDTH-1 -: 6] == HALT_OPCODE);
  assign deq     = ins_valid && ins_ready;
  // A full queue still accepts a new word when decode frees the head this cycle.
  assign enq_ok  = (q_count < 2'(QUEUE_DEPTH)) || deq;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    push          = 1'b0;
    flush         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = RESET_PC;
        end
      end
      ST_FETCH: begin
        if (redirect) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else if (enq_ok) begin
          push          = 1'b1;
          pc_d          = pc_q + 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_fifo #(
    .PC_WIDTH  (PC_WIDTH),
    .INS_WIDTH (INS_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_pc_i    (pc_q),
    .push_ins_i   (inscode),
    .pop_i        (deq),
    .flush_i      (flush),
    .count_o      (q_count),
    .head_valid_o (ins_valid),
    .head_pc_o    (ins_pc),
    .head_ins_o   (ins_out)
  );

  assign pc          = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = fetch_count_q;

endmodule : fetch_sequencer
